// File: rtl/uart_cmd_rx.sv
// Framed command receiver: SYNC, CMD, four big-endian argument bytes, XOR checksum.
// Bytes are taken on rising edges of the UART ready level, with an inter-byte timeout.
module uart_cmd_rx #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int          TIMEOUT = 240000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  cmd,
  output logic [31:0] arg,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic        busy
);

  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GET_CMD = 2'd1;
  localparam logic [1:0] GET_ARG = 2'd2;
  localparam logic [1:0] GET_CHK = 2'd3;

  logic [1:0]    state;
  logic [1:0]    idx;
  logic [TW-1:0] timer;
  logic          rdy_q;
  logic [7:0]    cmd_sh;
  logic [31:0]   arg_sh;
  logic [7:0]    xor_q;

  logic strobe;
  logic timed_out;

  // A ready level held high for many cycles yields exactly one strobe.
  assign strobe    = rx_ready & ~rdy_q;
  // A strobe in the same cycle as expiry keeps the packet alive.
  assign timed_out = (state != IDLE) && !strobe && (timer == TIMER_MAX);
  assign busy      = (state != IDLE);

  // NOTE: every register here is state, so all assignments are non-blocking;
  // that keeps reads of xor_q/idx in this block seeing last cycle's values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      timer     <= '0;
      rdy_q     <= 1'b0;
      cmd_sh    <= 8'h00;
      arg_sh    <= 32'h0;
      xor_q     <= 8'h00;
      cmd       <= 8'h00;
      arg       <= 32'h0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      rdy_q     <= rx_ready;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;

      // Saturating inter-byte timer, only meaningful while a packet is open.
      if (state == IDLE || strobe)
        timer <= '0;
      else if (timer != TIMER_MAX)
        timer <= timer + TW'(1);

      if (timed_out) begin
        cmd_err <= 1'b1;
        state   <= IDLE;
      end else if (strobe) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC)
              state <= GET_CMD;
          end
          GET_CMD: begin
            cmd_sh <= rx_data;
            xor_q  <= rx_data;
            idx    <= 2'd0;
            state  <= GET_ARG;
          end
          GET_ARG: begin
            arg_sh <= {arg_sh[23:0], rx_data};
            xor_q  <= xor_q ^ rx_data;
            idx    <= idx + 2'd1;
            if (idx == 2'd3)
              state <= GET_CHK;
          end
          GET_CHK: begin
            if (rx_data == xor_q) begin
              cmd       <= cmd_sh;
              arg       <= arg_sh;
              cmd_valid <= 1'b1;
            end else begin
              cmd_err   <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed packets plus random packets scored against
// a packet-level parser model of the byte stream.
module tb_uart_cmd_rx;

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  cmd;
  logic [31:0] arg;
  logic        cmd_valid;
  logic        cmd_err;
  logic        busy;

  uart_cmd_rx #(.SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .cmd       (cmd),
    .arg       (arg),
    .cmd_valid (cmd_valid),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse bookkeeping observed from the DUT.
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;

  // Expected totals and output values from the reference model.
  int          exp_valid = 0;
  int          exp_err   = 0;
  logic [7:0]  exp_cmd   = 8'h00;
  logic [31:0] exp_arg   = 32'h0;

  // Values seen one cycle after the most recent byte was presented.
  logic last_valid, last_err, last_busy;

  logic [7:0] seq[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) valid_cnt++;
      if (cmd_err)   err_cnt++;
      if (cmd_valid && cmd_err) both_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte at a negedge, hold ready for 'hold' cycles, then idle 3 cycles.
  task automatic send_byte(input logic [7:0] b, input int hold);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    last_valid = cmd_valid;
    last_err   = cmd_err;
    last_busy  = busy;
    repeat (hold - 1) @(negedge clk);
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Packet parser over a complete byte stream, starting from an idle receiver.
  task automatic model_run(input logic [7:0] q[$]);
    int i;
    logic [7:0] x;
    i = 0;
    while (i < q.size()) begin
      if (q[i] != SYNC || i + 6 >= q.size()) begin
        i++;
      end else begin
        x = q[i+1] ^ q[i+2] ^ q[i+3] ^ q[i+4] ^ q[i+5];
        if (q[i+6] == x) begin
          exp_valid++;
          exp_cmd = q[i+1];
          exp_arg = {q[i+2], q[i+3], q[i+4], q[i+5]};
        end else begin
          exp_err++;
        end
        i += 7;
      end
    end
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int hold);
    foreach (q[k]) send_byte(q[k], hold);
    model_run(q);
  endtask

  task automatic check_totals(input string tag);
    check({tag, " valid_count"}, 32'(valid_cnt), 32'(exp_valid));
    check({tag, " err_count"},   32'(err_cnt),   32'(exp_err));
    check({tag, " cmd"},         {24'h0, cmd},   {24'h0, exp_cmd});
    check({tag, " arg"},         arg,            exp_arg);
    check({tag, " both_high"},   32'(both_cnt),  32'd0);
    check({tag, " busy_idle"},   {31'h0, busy},  32'd0);
  endtask

  task automatic add_pkt(input logic [7:0] c, input logic [31:0] a, input logic good);
    logic [7:0] chk;
    chk = c ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0];
    if (!good) chk = chk ^ 8'($urandom_range(1, 255));
    seq.push_back(SYNC);
    seq.push_back(c);
    seq.push_back(a[31:24]);
    seq.push_back(a[23:16]);
    seq.push_back(a[15:8]);
    seq.push_back(a[7:0]);
    seq.push_back(chk);
  endtask

  initial begin
    int first_err_n;
    int err_before;
    logic [7:0] g;

    rst      = 1'b1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset cmd",       {24'h0, cmd},       32'h0);
    check("reset arg",       arg,                32'h0);
    check("reset cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("reset cmd_err",   {31'h0, cmd_err},   32'h0);
    check("reset busy",      {31'h0, busy},      32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good packet; checksum of 10,12,34,56,78 is 18.
    seq = {8'hA5, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h18};
    send_seq(seq, 1);
    check("good pulse", {31'h0, last_valid}, 32'd1);
    check("good busy_falls", {31'h0, last_busy}, 32'd0);
    check("good cmd_const", {24'h0, cmd}, 32'h10);
    check("good arg_const", arg, 32'h12345678);
    check_totals("good");

    // Bad checksum: outputs hold, one error pulse.
    seq = {8'hA5, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_seq(seq, 1);
    check("badchk pulse", {31'h0, last_err}, 32'd1);
    check("badchk no_valid", {31'h0, last_valid}, 32'd0);
    check_totals("badchk");

    // Garbage ahead of a packet produces no pulses.
    seq = {8'h00, 8'hFF};
    send_seq(seq, 1);
    check("garbage busy", {31'h0, busy}, 32'd0);
    check_totals("garbage");
    seq = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03};
    send_seq(seq, 1);
    check("garbage_pkt cmd", {24'h0, cmd}, 32'h01);
    check("garbage_pkt arg", arg, 32'h00000002);
    check_totals("garbage_pkt");

    // Timeout: A5, 20, then silence; error lands one cycle after timer hits TIMEOUT.
    send_byte(8'hA5, 1);
    check("timeout busy", {31'h0, busy}, 32'd1);
    err_before  = err_cnt;
    first_err_n = 0;
    rx_data  = 8'h20;
    rx_ready = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= TIMEOUT + 6; n++) begin
      @(posedge clk);
      @(negedge clk);
      rx_ready = 1'b0;
      if (cmd_err && first_err_n == 0) first_err_n = n;
    end
    check("timeout latency", 32'(first_err_n), 32'(TIMEOUT + 1));
    check("timeout one_pulse", 32'(err_cnt - err_before), 32'd1);
    exp_err++;
    check_totals("timeout");
    seq = {8'hA5, 8'h5A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    seq[6] = seq[1] ^ seq[2] ^ seq[3] ^ seq[4] ^ seq[5];
    send_seq(seq, 1);
    check_totals("after_timeout");

    // Ready held high for 50 cycles per byte still counts each byte once.
    seq = {8'hA5, 8'h33, 8'h01, 8'h02, 8'h03, 8'h04, 8'h37};
    send_seq(seq, 50);
    check_totals("held");

    // Random packets, some with corrupted checksums, with non-SYNC garbage ahead.
    for (int t = 0; t < 10; t++) begin
      seq = {};
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        g = 8'($urandom);
        if (g == SYNC) g = 8'h00;
        seq.push_back(g);
      end
      add_pkt(8'($urandom), $urandom, ($urandom_range(0, 9) < 7));
      send_seq(seq, int'($urandom_range(1, 4)));
      check_totals($sformatf("rand%0d", t));
    end

    // Reset mid-packet discards it silently; the next packet decodes.
    send_byte(8'hA5, 1);
    send_byte(8'h10, 1);
    send_byte(8'h12, 1);
    err_before = err_cnt;
    rst = 1'b1;
    #1;
    check("midrst cmd",  {24'h0, cmd},     32'h0);
    check("midrst arg",  arg,              32'h0);
    check("midrst busy", {31'h0, busy},    32'h0);
    check("midrst pulses", {30'h0, cmd_valid, cmd_err}, 32'h0);
    exp_cmd = 8'h00;
    exp_arg = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    seq = {8'hA5, 8'hC3, 8'h11, 8'h22, 8'h44, 8'h88, 8'h00};
    seq[6] = seq[1] ^ seq[2] ^ seq[3] ^ seq[4] ^ seq[5];
    send_seq(seq, 2);
    check("midrst no_err", 32'(err_cnt - err_before), 32'd0);
    check_totals("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
